// File: rtl/zb_fifo_pkg.sv
// Shared constants, width helpers and the per-channel status type for zb_chan_fifo.
// Optional occupancy output is enabled with ZB_FIFO_LEVEL_EN.
package zb_fifo_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_CH = 2;

  // A single channel still needs a 1-bit select so the port never collapses to zero width.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic ovf;
    logic unf;
  } ch_status_t;

endpackage

// File: rtl/zb_chan_fifo_if.sv
// Request/status bundle of the multi-channel FIFO bank.
// outLevel exists only when ZB_FIFO_LEVEL_EN is defined.
interface zb_chan_fifo_if #(
  parameter int WIDTH  = zb_fifo_pkg::DEF_WIDTH,
  parameter int DEPTH  = zb_fifo_pkg::DEF_DEPTH,
  parameter int NUM_CH = zb_fifo_pkg::DEF_NUM_CH
);
  localparam int CH_W = zb_fifo_pkg::ch_width(NUM_CH);

  // Requests are sampled every rising edge with no backpressure: a write/read
  // enable is either accepted or refused in that cycle (status tells which),
  // and an accepted read returns outData with a one-cycle outValid pulse.
  logic [WIDTH-1:0]  inData;
  logic              inWriteEnable;
  logic [CH_W-1:0]   inWrSel;
  logic              inReadEnable;
  logic [CH_W-1:0]   inRdSel;
  logic              inClearFlags;
  logic [WIDTH-1:0]  outData;
  logic              outValid;
  logic [NUM_CH-1:0] outFull;
  logic [NUM_CH-1:0] outEmpty;
  logic [NUM_CH-1:0] outOverflow;
  logic [NUM_CH-1:0] outUnderflow;
`ifdef ZB_FIFO_LEVEL_EN
  localparam int CNT_W = zb_fifo_pkg::cnt_width(DEPTH);
  logic [NUM_CH*CNT_W-1:0] outLevel;
`endif

  modport master (
    output inData, inWriteEnable, inWrSel, inReadEnable, inRdSel, inClearFlags,
    input  outData, outValid, outFull, outEmpty, outOverflow, outUnderflow
`ifdef ZB_FIFO_LEVEL_EN
    , input outLevel
`endif
  );

  modport slave (
    input  inData, inWriteEnable, inWrSel, inReadEnable, inRdSel, inClearFlags,
    output outData, outValid, outFull, outEmpty, outOverflow, outUnderflow
`ifdef ZB_FIFO_LEVEL_EN
    , output outLevel
`endif
  );

endinterface

// File: rtl/zb_fifo_ch.sv
// One FIFO channel: storage, wrapping pointers, occupancy count and sticky error flags.
// The level port is present only when ZB_FIFO_LEVEL_EN is defined.
module zb_fifo_ch
  import zb_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             wr_err,
  input  logic             rd_err,
  input  logic             clr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output ch_status_t       status
`ifdef ZB_FIFO_LEVEL_EN
  , output logic [CNT_W-1:0] level
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      count <= count + CNT_W'(1);
      else if (rd_en && !wr_en) count <= count - CNT_W'(1);
      // A fresh error outranks a clear issued in the same cycle.
      if (wr_err)   ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
      if (rd_err)   unf <= 1'b1;
      else if (clr) unf <= 1'b0;
    end
  end

  // Storage needs no reset: the cleared count makes every old entry unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data      = mem[rd_ptr];
  assign status.full  = (count == CNT_W'(DEPTH));
  assign status.empty = (count == '0);
  assign status.ovf   = ovf;
  assign status.unf   = unf;
`ifdef ZB_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: rtl/zb_chan_fifo.sv
// Multi-channel FIFO bank: write/read select decode, full-channel pass-through rule, registered read port.
// Define ZB_FIFO_LEVEL_EN to export per-channel occupancy on outLevel.
module zb_chan_fifo
  import zb_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input logic           inClock,
  input logic           inReset,
  zb_chan_fifo_if.slave bus
);

  localparam int CH_W = ch_width(NUM_CH);

  ch_status_t        st      [NUM_CH];
  logic [WIDTH-1:0]  rd_data [NUM_CH];
  logic [NUM_CH-1:0] wr_acc, rd_acc, wr_err, rd_err;
  logic [NUM_CH-1:0] full_v, empty_v, ovf_v, unf_v;
  logic [WIDTH-1:0]  rd_mux;
  logic              rd_any;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q;

  // A select beyond NUM_CH matches no channel, so it is dropped without any flag.
  always_comb begin
    wr_acc  = '0;
    rd_acc  = '0;
    wr_err  = '0;
    rd_err  = '0;
    full_v  = '0;
    empty_v = '0;
    ovf_v   = '0;
    unf_v   = '0;
    rd_mux  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_acc[i] = bus.inReadEnable && (bus.inRdSel == CH_W'(i)) && !st[i].empty;
      rd_err[i] = bus.inReadEnable && (bus.inRdSel == CH_W'(i)) && st[i].empty;
      // A full channel still takes a write when the same cycle pops from it.
      wr_acc[i] = bus.inWriteEnable && (bus.inWrSel == CH_W'(i)) && (!st[i].full || rd_acc[i]);
      wr_err[i] = bus.inWriteEnable && (bus.inWrSel == CH_W'(i)) && st[i].full && !rd_acc[i];
      if (rd_acc[i]) rd_mux = rd_data[i];
      full_v[i]  = st[i].full;
      empty_v[i] = st[i].empty;
      ovf_v[i]   = st[i].ovf;
      unf_v[i]   = st[i].unf;
    end
    rd_any = |rd_acc;
  end

`ifdef ZB_FIFO_LEVEL_EN
  localparam int CNT_W = cnt_width(DEPTH);
  logic [NUM_CH*CNT_W-1:0] level_v;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    zb_fifo_ch #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ch (
      .clk     (inClock),
      .rst     (inReset),
      .wr_en   (wr_acc[i]),
      .rd_en   (rd_acc[i]),
      .wr_err  (wr_err[i]),
      .rd_err  (rd_err[i]),
      .clr     (bus.inClearFlags),
      .wr_data (bus.inData),
      .rd_data (rd_data[i]),
      .status  (st[i])
`ifdef ZB_FIFO_LEVEL_EN
      , .level (level_v[i*CNT_W +: CNT_W])
`endif
    );
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_any;
      if (rd_any) data_q <= rd_mux;
    end
  end

  assign bus.outData      = data_q;
  assign bus.outValid     = valid_q;
  assign bus.outFull      = full_v;
  assign bus.outEmpty     = empty_v;
  assign bus.outOverflow  = ovf_v;
  assign bus.outUnderflow = unf_v;
`ifdef ZB_FIFO_LEVEL_EN
  assign bus.outLevel     = level_v;
`endif

endmodule

// File: tb/tb_zb_chan_fifo.sv
// Bench for zb_chan_fifo (WIDTH=4, DEPTH=4, NUM_CH=2): directed vector table, mid-run reset, random run vs queue model.
// Also covers outLevel when ZB_FIFO_LEVEL_EN is defined.
module tb_zb_chan_fifo;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 4;
  localparam int NUM_CH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  zb_chan_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

  zb_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .inClock (clk),
    .inReset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       ws;
    logic [3:0] wd;
    logic       re;
    logic       rs;
    logic       clr;
    logic       v;
    logic [3:0] d;
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] ovf;
    logic [1:0] unf;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference: one queue per channel plus sticky flags and held data.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [1:0]       m_ovf;
  logic [1:0]       m_unf;
  logic [WIDTH-1:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic we, input logic ws, input logic [3:0] wd,
                     input logic re, input logic rs, input logic clr,
                     input logic v, input logic [3:0] d, input logic [1:0] full,
                     input logic [1:0] empty, input logic [1:0] ovf, input logic [1:0] unf);
    vec_t t;
    t.we = we; t.ws = ws; t.wd = wd; t.re = re; t.rs = rs; t.clr = clr;
    t.v = v; t.d = d; t.full = full; t.empty = empty; t.ovf = ovf; t.unf = unf;
    tbl.push_back(t);
  endtask

  // Drive one cycle of requests away from the edge, then sample 1 time unit after the edge.
  task automatic apply(input logic we, input logic ws, input logic [3:0] wd,
                       input logic re, input logic rs, input logic clr);
    bus.inWriteEnable = we;
    bus.inWrSel       = ws;
    bus.inData        = wd;
    bus.inReadEnable  = re;
    bus.inRdSel       = rs;
    bus.inClearFlags  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.inWriteEnable = 1'b0;
    bus.inWrSel       = 1'b0;
    bus.inData        = '0;
    bus.inReadEnable  = 1'b0;
    bus.inRdSel       = 1'b0;
    bus.inClearFlags  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_empty", bus.outEmpty, 2'b11);
    check("rst_full", bus.outFull, 2'b00);
    check("rst_valid", bus.outValid, 1'b0);
    check("rst_data", bus.outData, 4'h0);
    check("rst_ovf", bus.outOverflow, 2'b00);
    check("rst_unf", bus.outUnderflow, 2'b00);
`ifdef ZB_FIFO_LEVEL_EN
    check("rst_level", bus.outLevel, 6'd0);
`endif
  endtask

  function automatic int m_size(input logic c);
    return c ? q1.size() : q0.size();
  endfunction

  task automatic rand_step();
    logic             we, ws, re, rs, clr;
    logic [WIDTH-1:0] wd;
    logic             racc, wacc;
    logic [WIDTH-1:0] got;
    we  = 1'($urandom_range(0, 1));
    ws  = 1'($urandom_range(0, 1));
    wd  = 4'($urandom_range(0, 15));
    re  = 1'($urandom_range(0, 1));
    rs  = 1'($urandom_range(0, 1));
    clr = ($urandom_range(0, 15) == 0);
    racc = re && (m_size(rs) > 0);
    wacc = we && ((m_size(ws) < DEPTH) || (racc && (rs == ws)));
    if (racc) begin
      got = rs ? q1.pop_front() : q0.pop_front();
      exp_q.push_back(got);
      m_data = got;
    end
    if (wacc) begin
      if (ws) q1.push_back(wd);
      else    q0.push_back(wd);
    end
    for (int c = 0; c < 2; c++) begin
      if (we && (ws == c[0]) && !wacc) m_ovf[c] = 1'b1;
      else if (clr)                     m_ovf[c] = 1'b0;
      if (re && (rs == c[0]) && !racc) m_unf[c] = 1'b1;
      else if (clr)                     m_unf[c] = 1'b0;
    end
    apply(we, ws, wd, re, rs, clr);
    check("rnd_valid", bus.outValid, racc);
    if (bus.outValid === 1'b1) begin
      if (exp_q.size() == 0) check("rnd_unexpected", bus.outValid, 1'b0);
      else                   check("rnd_data", bus.outData, exp_q.pop_front());
    end else begin
      check("rnd_hold", bus.outData, m_data);
    end
    check("rnd_full", bus.outFull, {q1.size() == DEPTH, q0.size() == DEPTH});
    check("rnd_empty", bus.outEmpty, {q1.size() == 0, q0.size() == 0});
    check("rnd_ovf", bus.outOverflow, m_ovf);
    check("rnd_unf", bus.outUnderflow, m_unf);
`ifdef ZB_FIFO_LEVEL_EN
    check("rnd_level", bus.outLevel, {3'(q1.size()), 3'(q0.size())});
`endif
  endtask

  initial begin
    //  we ws wd    re rs clr   v  d     full   empty  ovf    unf
    add(1, 1, 4'hD, 0, 0, 0,    0, 4'h0, 2'b00, 2'b01, 2'b00, 2'b00);
    add(1, 0, 4'h3, 0, 0, 0,    0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 0, 4'h0, 1, 1, 0,    1, 4'hD, 2'b00, 2'b10, 2'b00, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h3, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 0, 4'h1, 0, 0, 0,    0, 4'h3, 2'b00, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h2, 0, 0, 0,    0, 4'h3, 2'b00, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h3, 0, 0, 0,    0, 4'h3, 2'b00, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h4, 0, 0, 0,    0, 4'h3, 2'b01, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h5, 0, 0, 0,    0, 4'h3, 2'b01, 2'b10, 2'b01, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h1, 2'b00, 2'b10, 2'b01, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h2, 2'b00, 2'b10, 2'b01, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h3, 2'b00, 2'b10, 2'b01, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h4, 2'b00, 2'b11, 2'b01, 2'b00);
    add(0, 0, 4'h0, 0, 0, 1,    0, 4'h4, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 0, 4'h1, 0, 0, 0,    0, 4'h4, 2'b00, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h2, 0, 0, 0,    0, 4'h4, 2'b00, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h3, 0, 0, 0,    0, 4'h4, 2'b00, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h4, 0, 0, 0,    0, 4'h4, 2'b01, 2'b10, 2'b00, 2'b00);
    add(1, 0, 4'h9, 1, 0, 0,    1, 4'h1, 2'b01, 2'b10, 2'b00, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h2, 2'b00, 2'b10, 2'b00, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h3, 2'b00, 2'b10, 2'b00, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h4, 2'b00, 2'b10, 2'b00, 2'b00);
    add(0, 0, 4'h0, 1, 0, 0,    1, 4'h9, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 1, 4'h7, 1, 1, 0,    0, 4'h9, 2'b00, 2'b01, 2'b00, 2'b10);
    add(0, 0, 4'h0, 1, 1, 0,    1, 4'h7, 2'b00, 2'b11, 2'b00, 2'b10);
    add(0, 0, 4'h0, 0, 0, 1,    0, 4'h7, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 0, 4'hA, 1, 1, 0,    0, 4'h7, 2'b00, 2'b10, 2'b00, 2'b10);
    add(1, 1, 4'hB, 1, 0, 0,    1, 4'hA, 2'b00, 2'b01, 2'b00, 2'b10);
    add(0, 0, 4'h0, 1, 0, 1,    0, 4'hA, 2'b00, 2'b01, 2'b00, 2'b01);
    add(0, 0, 4'h0, 1, 1, 1,    1, 4'hB, 2'b00, 2'b11, 2'b00, 2'b00);

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].we, tbl[i].ws, tbl[i].wd, tbl[i].re, tbl[i].rs, tbl[i].clr);
      check($sformatf("vec%0d_valid", i), bus.outValid, tbl[i].v);
      check($sformatf("vec%0d_data", i), bus.outData, tbl[i].d);
      check($sformatf("vec%0d_full", i), bus.outFull, tbl[i].full);
      check($sformatf("vec%0d_empty", i), bus.outEmpty, tbl[i].empty);
      check($sformatf("vec%0d_ovf", i), bus.outOverflow, tbl[i].ovf);
      check($sformatf("vec%0d_unf", i), bus.outUnderflow, tbl[i].unf);
    end

    // Mid-operation reset: leave two entries in ch0 with outValid high, then pulse reset.
    apply(1, 0, 4'h1, 0, 0, 0);
    apply(1, 0, 4'h2, 0, 0, 0);
    apply(1, 0, 4'h3, 0, 0, 0);
    apply(0, 0, 4'h0, 1, 0, 0);
    check("mid_pre_valid", bus.outValid, 1'b1);
    check("mid_pre_empty", bus.outEmpty, 2'b10);
`ifdef ZB_FIFO_LEVEL_EN
    check("mid_pre_level", bus.outLevel, {3'd0, 3'd2});
`endif
    bus.inReadEnable = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_empty", bus.outEmpty, 2'b11);
    check("mid_rst_valid", bus.outValid, 1'b0);
    check("mid_rst_data", bus.outData, 4'h0);
`ifdef ZB_FIFO_LEVEL_EN
    check("mid_rst_level", bus.outLevel, 6'd0);
`endif
    #3;
    rst = 1'b0;
    apply(0, 0, 4'h0, 1, 0, 0);
    check("mid_post_valid", bus.outValid, 1'b0);
    check("mid_post_unf", bus.outUnderflow, 2'b01);
    check("mid_post_empty", bus.outEmpty, 2'b11);

    do_reset();
    q0.delete();
    q1.delete();
    exp_q.delete();
    m_ovf  = '0;
    m_unf  = '0;
    m_data = '0;
    for (int i = 0; i < 600; i++) rand_step();
    check("rnd_scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zb_chan_fifo.md
Name: zb_chan_fifo

Overview:
- Parametrised multi-channel FIFO bank for the baseband data path. It is the successor of the single nibble FIFO plus the fixed DEMUX/MUX routing around it.
- Write side: input data is steered by a write-select into one of NUM_CH independent FIFOs.
- Read side: a read-select picks the channel to pop. Output data is registered.
- Per-channel full/empty status and sticky overflow/underflow flags are exported to the control logic.

Parameters:
- WIDTH, 4: data word width in bits.
- DEPTH, 8: entries per channel. Must be a power of 2 and >= 2.
- NUM_CH, 2: number of channels, >= 1.

Ports:
- inClock  in  1  system clock, rising edge.
- inReset  in  1  asynchronous, active-high reset.
- inData  in  WIDTH  write data.
- inWriteEnable  in  1  write request.
- inWrSel  in  CH_W  target channel for the write. CH_W = max(1, $clog2(NUM_CH)).
- inReadEnable  in  1  read request.
- inRdSel  in  CH_W  source channel for the read.
- inClearFlags  in  1  synchronous clear of all sticky flags.
- outData  out  WIDTH  registered read data.
- outValid  out  1  outData valid. Single-cycle pulse.
- outFull  out  NUM_CH  per-channel full.
- outEmpty  out  NUM_CH  per-channel empty.
- outOverflow  out  NUM_CH  sticky: a write was dropped because the channel was full.
- outUnderflow  out  NUM_CH  sticky: a read was refused because the channel was empty.

Behaviour:
- Reset: asynchronous, active-high.
  - All pointers and counts go to 0.
  - outData=0, outValid=0, outFull=0, outEmpty=all 1, outOverflow=0, outUnderflow=0.
  - Reset asserted mid-operation discards all stored data immediately. No partial state survives.
- Per-channel state:
  - wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrapping modulo DEPTH.
  - count, $clog2(DEPTH+1) bits.
  - full = (count==DEPTH); empty = (count==0). Both are derived from registered count, so status is valid the cycle after the change.
- Write accepted when all of the following hold:
  - inWriteEnable=1;
  - inWrSel < NUM_CH;
  - the channel is not full, OR the channel is full and a read of the same channel is accepted in the same cycle.
  - On accept: mem[wr_ptr] <= inData; wr_ptr++.
- Read accepted when inReadEnable=1, inRdSel < NUM_CH and the channel is not empty.
  - On accept: outData <= mem[rd_ptr]; rd_ptr++; outValid=1 next cycle.
  - Latency: 1 clock from request to data.
- No bypass. A write and a read to an empty channel in the same cycle:
  - the write is accepted;
  - the read is refused and sets outUnderflow for that channel.
- Count update per channel: +1 on write only, -1 on read only, unchanged on both.
- Writes and reads to different channels in the same cycle are fully independent.
- Write refused because the channel is full: data is dropped and outOverflow[ch] <= 1.
- Read refused because the channel is empty: outValid=0, outData holds its previous value, outUnderflow[ch] <= 1.
- Select >= NUM_CH (non-power-of-2 NUM_CH): the request is silently ignored. No flag is set.
- Sticky flags:
  - inClearFlags clears all of them.
  - A new error in the same cycle as inClearFlags wins, so the flag ends up 1.

Optional Feature:
- Macro: ZB_FIFO_LEVEL_EN.
- Defined: adds output port outLevel [NUM_CH*CNT_W-1:0], where CNT_W=$clog2(DEPTH+1). Channel i occupancy is in bits [i*CNT_W +: CNT_W], taken directly from the registered count. Reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package zb_fifo_pkg contains:
  - the default constants for WIDTH, DEPTH and NUM_CH;
  - a function computing CH_W and CNT_W (including the max(1, ...) guard);
  - the typedef for per-channel status (full, empty, ovf, unf).
- Sub-module zb_fifo_ch: one channel (memory, pointers, count, flags) with wr_en/rd_en/clr inputs. Instantiated NUM_CH times in a generate loop.
- Top level holds the select decode, the simultaneous full-write/read rule, and the registered output mux.

Test Plan (WIDTH=4, DEPTH=4, NUM_CH=2 unless noted):
- Reset: hold inReset=1 for 3 cycles, then release -> outEmpty=2'b11, outFull=0, outValid=0, outData=0, flags=0.
- Basic routing: write 4'hD to ch1, then 4'h3 to ch0. Read ch1 -> outData=4'hD with outValid one cycle after the request. Read ch0 -> 4'h3.
- Fill and overflow: write 1,2,3,4 to ch0, giving outFull[0]=1. Write 5 -> outOverflow[0]=1 and the data is dropped. Read 4 times -> 1,2,3,4, then outEmpty[0]=1.
- Full simultaneous: with ch0 full, write 9 and read ch0 in the same cycle -> both accepted, outFull[0] stays 1, outOverflow stays 0. Later reads return 2,3,4,9.
- Empty simultaneous and underflow: with ch1 empty, write 7 and read ch1 in the same cycle -> outValid=0, outUnderflow[1]=1. Next read -> 7. Then inClearFlags=1 -> flags return to 0.
- Mid-operation reset: with ch0 holding 2 entries, pulse inReset for half a cycle -> immediate outEmpty[0]=1 and outValid=0. With ZB_FIFO_LEVEL_EN defined, outLevel goes 2 -> 0.
